divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//   Sequential restoring divider: dividend / divisor -> quotient, remainder.
//   Inverse of the 4x4 shift-add multiplier; an 8-bit product divided by a
//   4-bit operand recovers the other operand. One quotient bit per cycle.
//   The FSM and the datapath live in one module. Start/done handshake.
// PARAMETERS
//   DW  8  dividend and quotient width (bits)
//   VW  4  divisor and remainder width (bits)
// PORTS
//   clk       in   1   clock; all state updates on the rising edge
//   rst       in   1   reset; synchronous, active-low (0 = reset)
//   start     in   1   request; sampled only in IDLE
//   dividend  in   DW  unsigned dividend; captured when start is accepted
//   divisor   in   VW  unsigned divisor; captured when start is accepted
//   quotient  out  DW  unsigned quotient; valid from the done cycle onward
//   remainder out  VW  unsigned remainder; valid from the done cycle onward
//   busy      out  1   high in CALC and DONE
//   done      out  1   one-cycle pulse; results valid in this cycle
//   dz        out  1   divide-by-zero flag; valid with done
// BEHAVIOUR
//   Reset: rst=0 at a rising edge sets state=IDLE and clears quotient,
//     remainder, busy, done, dz and all internal registers. Reset takes
//     priority over every other input, including in the middle of CALC.
//   States: IDLE, CALC, DONE.
//   IDLE: when start=1 at an edge, capture the operands.
//     If divisor != 0: set the partial remainder R (VW+1 bits) to 0, load
//     Q with the dividend, set cnt = DW-1 and go to CALC.
//     If divisor == 0: go to DONE with quotient = all ones, remainder = 0
//     and dz = 1.
//   CALC: one restoring step per cycle:
//     {R,Q} <= {R,Q} << 1
//     T = R_shifted - {1'b0,divisor}
//     if T >= 0: R <= T, Q[0] <= 1; else Q[0] <= 0 (restore).
//     When cnt == 0, go to DONE. Otherwise decrement cnt.
//   DONE: done=1 for exactly one cycle; quotient = Q, remainder = R[VW-1:0].
//     Go to IDLE on the next edge.
//   Latency: start accepted at edge 0 -> done high after edge DW+1
//     (9 cycles for the defaults). Divide-by-zero: done high after edge 1.
//   Results hold until the next accepted start. They are not cleared at DONE.
//   start is ignored in CALC and DONE; a new request needs start high in IDLE.
//   Inputs may change freely after acceptance; only captured values are used.
//   R never exceeds divisor-1 after a step, so VW+1 bits are sufficient.
//   dz is cleared when the next start is accepted with a nonzero divisor.
//   Quotient width is DW, so no overflow is possible.
// TESTING
//   1. 54 / 9 (0x36 / 0x9) -> quotient=6, remainder=0, dz=0; done exactly
//      9 cycles after the start edge, busy high during those cycles.
//   2. 200 / 13 -> quotient=15, remainder=5; 255 / 1 -> quotient=255,
//      remainder=0.
//   3. 7 / 15 -> quotient=0, remainder=7 (dividend < divisor).
//   4. 100 / 0 -> dz=1, quotient=0xFF, remainder=0, done 1 cycle after start;
//      then 54 / 9 -> dz=0.
//   5. Start pulsed again at cycle 3 of CALC with other operands -> ignored;
//      the original result is delivered at the original done cycle.
//   6. rst=0 at cycle 4 of CALC -> next cycle: IDLE, all outputs 0, no done
//      pulse; a fresh start then runs normally.

Source files
------------

// File: rtl/divider_if.sv
// Handshake and result bundle between a divider client and the divider core.
interface divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          dz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, dz
  );
endinterface

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake,
// results and the divide-by-zero flag held until the next accepted request.
module divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [VW:0]   r_reg, r_next;
  logic [DW-1:0] q_reg, q_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [VW-1:0] divisor_reg, divisor_next;
  logic [DW-1:0] quotient_reg, quotient_next;
  logic [VW-1:0] remainder_reg, remainder_next;
  logic          dz_reg, dz_next;
  logic          done_reg, done_next;

  logic [VW+1:0] r_shift;
  logic [VW+1:0] trial;

  // R stays below the divisor, so the top bit of trial is a clean borrow flag.
  assign r_shift = {r_reg, q_reg[DW-1]};
  assign trial   = r_shift - {2'b00, divisor_reg};

  always_comb begin
    state_next     = state_reg;
    r_next         = r_reg;
    q_next         = q_reg;
    cnt_next       = cnt_reg;
    divisor_next   = divisor_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dz_next        = dz_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          divisor_next = bus.divisor;
          r_next       = '0;
          if (bus.divisor != '0) begin
            q_next     = bus.dividend;
            cnt_next   = CW'(DW - 1);
            dz_next    = 1'b0;
            state_next = CALC;
          end else begin
            q_next     = '1;
            dz_next    = 1'b1;
            state_next = DONE;
          end
        end
      end

      CALC: begin
        if (!trial[VW+1]) begin
          r_next = trial[VW:0];
          q_next = {q_reg[DW-2:0], 1'b1};
        end else begin
          r_next = r_shift[VW:0];
          q_next = {q_reg[DW-2:0], 1'b0};
        end
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      DONE: begin
        // Results are published together with the done pulse on this edge.
        done_next      = 1'b1;
        quotient_next  = q_reg;
        remainder_next = r_reg[VW-1:0];
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      cnt_reg       <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_reg        <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      r_reg         <= r_next;
      q_reg         <= q_next;
      cnt_reg       <= cnt_next;
      divisor_reg   <= divisor_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dz_reg        <= dz_next;
      done_reg      <= done_next;
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = done_reg;
  assign bus.dz        = dz_reg;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the restoring divider: directed requests push expected
// results; a monitor pops and compares on every done pulse.
module tb_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divider_if #(.DW(DW), .VW(VW)) bus ();

  divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("done q=%0d r=%0d dz=%0d cycle=%0d", bus.quotient, bus.remainder, bus.dz, cyc);
        chk("quotient", 32'(bus.quotient), 32'(mon_e.q));
        chk("remainder", 32'(bus.remainder), 32'(mon_e.r));
        chk("dz", 32'(bus.dz), 32'(mon_e.dz));
        chk("done_cycle", 32'(cyc), 32'(mon_e.at));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  // Drive one request; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                       input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    e.at = cyc + 1 + ((b == '0) ? 1 : DW + 1);
    sb.push_back(e);
    $display("start %0d / %0d expect q=%0d r=%0d dz=%0d at cycle %0d", a, b, eq, er, edz, e.at);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'hA5;
    bus.divisor  = 4'h3;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=pending expected=empty (cycle %0d)", cyc);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_quotient", 32'(bus.quotient), 32'd0);
    chk("reset_remainder", 32'(bus.remainder), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_dz", 32'(bus.dz), 32'd0);
    rst = 1'b1;

    // 54 / 9 with busy/done tracked through the whole calculation.
    issue(8'd54, 4'd9, 8'd6, 4'd0, 1'b0);
    chk("busy_calc", 32'(bus.busy), 32'd1);
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      chk("busy_calc", 32'(bus.busy), 32'd1);
      chk("no_early_done", 32'(bus.done), 32'd0);
    end
    wait_idle();

    issue(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    wait_idle();
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_quotient", 32'(bus.quotient), 32'd255);
    chk("hold_remainder", 32'(bus.remainder), 32'd0);

    issue(8'd7, 4'd15, 8'd0, 4'd7, 1'b0);
    wait_idle();

    // Divide by zero, then a normal request must clear dz.
    issue(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
    chk("dz_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    issue(8'd54, 4'd9, 8'd6, 4'd0, 1'b0);
    chk("dz_cleared_on_start", 32'(bus.dz), 32'd0);
    wait_idle();

    // A start pulse during CALC must be ignored.
    issue(8'd54, 4'd9, 8'd6, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd13;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    // Reset in the middle of CALC aborts without a done pulse.
    issue(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_quotient", 32'(bus.quotient), 32'd0);
    chk("abort_remainder", 32'(bus.remainder), 32'd0);
    chk("abort_dz", 32'(bus.dz), 32'd0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
